// File: rtl/datapath_pkg.sv
// Shared constants for the register-bank/ALU datapath: ALU opcodes, bus indices
// and the division sequencer state encoding.
package datapath_pkg;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_INC   = 3'd2;
    localparam logic [2:0] ALU_PASSA = 3'd3;
    localparam logic [2:0] ALU_AND   = 3'd4;
    localparam logic [2:0] ALU_OR    = 3'd5;
    localparam logic [2:0] ALU_XOR   = 3'd6;
    localparam logic [2:0] ALU_SHL   = 3'd7;

    // Bus A/B indices; on bus C index 7 means "write nothing".
    localparam logic [2:0] REG_R0   = 3'd0;
    localparam logic [2:0] REG_R1   = 3'd1;
    localparam logic [2:0] REG_R2   = 3'd2;
    localparam logic [2:0] REG_ZERO = 3'd3;
    localparam logic [2:0] REG_K0   = 3'd6;
    localparam logic [2:0] REG_K1   = 3'd7;
    localparam logic [2:0] WR_NONE  = 3'd7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_N,
        ST_LOAD_D,
        ST_CLR_Q,
        ST_CHK_Z,
        ST_CMP,
        ST_SUBT,
        ST_INCQ,
        ST_DONE,
        ST_ERR
    } div_state_e;

endpackage

// File: rtl/div_statemachine.sv
// Moore sequencer doing unsigned 8-bit division by repeated subtraction on the
// shared datapath: quotient ends in R2, remainder in R0.
module div_statemachine
    import datapath_pkg::*;
#(
    parameter int SELECTIONALU  = 3,
    parameter int SELECTIONDECO = 3,
    parameter int SRC_N         = 6,
    parameter int SRC_D         = 7
) (
    input  logic                     clk,
    input  logic                     lowRst,
    input  logic                     sStart,
    input  logic                     sOverflow,
    input  logic                     sNegative,
    input  logic                     sZero,
    input  logic                     sPar,
    input  logic                     sCarry,
    output logic [SELECTIONDECO-1:0] sSelDecoA,
    output logic [SELECTIONDECO-1:0] sSelDecoB,
    output logic [SELECTIONDECO-1:0] sSelDecoC,
    output logic [SELECTIONALU-1:0]  sSelAlu,
    output logic                     sBusy,
    output logic                     sDone,
    output logic                     sDivZero
);

    div_state_e state_q;
    div_state_e state_d;

    logic unused_flags;
    assign unused_flags = sOverflow ^ sNegative ^ sPar;

    always_ff @(posedge clk or negedge lowRst) begin
        if (!lowRst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Idle control word is the default; each state overrides only what it needs.
    always_comb begin
        state_d   = state_q;
        sSelDecoA = SELECTIONDECO'(REG_ZERO);
        sSelDecoB = SELECTIONDECO'(REG_ZERO);
        sSelDecoC = SELECTIONDECO'(WR_NONE);
        sSelAlu   = SELECTIONALU'(ALU_ADD);
        sBusy     = 1'b1;
        sDone     = 1'b0;
        sDivZero  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                sBusy = 1'b0;
                if (sStart) begin
                    state_d = ST_LOAD_N;
                end
            end
            ST_LOAD_N: begin
                sSelDecoA = SELECTIONDECO'(SRC_N);
                sSelDecoC = SELECTIONDECO'(REG_R0);
                state_d   = ST_LOAD_D;
            end
            ST_LOAD_D: begin
                sSelDecoA = SELECTIONDECO'(SRC_D);
                sSelDecoC = SELECTIONDECO'(REG_R1);
                state_d   = ST_CLR_Q;
            end
            ST_CLR_Q: begin
                sSelDecoC = SELECTIONDECO'(REG_R2);
                state_d   = ST_CHK_Z;
            end
            ST_CHK_Z: begin
                sSelDecoA = SELECTIONDECO'(REG_R1);
                state_d   = sZero ? ST_ERR : ST_CMP;
            end
            // Borrow on R0 - R1 means the remainder is already below the divisor.
            ST_CMP: begin
                sSelDecoA = SELECTIONDECO'(REG_R0);
                sSelDecoB = SELECTIONDECO'(REG_R1);
                sSelAlu   = SELECTIONALU'(ALU_SUB);
                state_d   = sCarry ? ST_DONE : ST_SUBT;
            end
            ST_SUBT: begin
                sSelDecoA = SELECTIONDECO'(REG_R0);
                sSelDecoB = SELECTIONDECO'(REG_R1);
                sSelDecoC = SELECTIONDECO'(REG_R0);
                sSelAlu   = SELECTIONALU'(ALU_SUB);
                state_d   = ST_INCQ;
            end
            ST_INCQ: begin
                sSelDecoA = SELECTIONDECO'(REG_R2);
                sSelDecoC = SELECTIONDECO'(REG_R2);
                sSelAlu   = SELECTIONALU'(ALU_INC);
                state_d   = ST_CMP;
            end
            ST_DONE: begin
                sDone   = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                sDone    = 1'b1;
                sDivZero = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_div_statemachine.sv
// Bench for div_statemachine: behavioural register bank/ALU around the sequencer,
// randomized divisions scored against plain integer division.
module tb_div_statemachine;
    import datapath_pkg::*;

    logic       clk = 1'b0;
    logic       lowRst;
    logic       sStart;
    logic       sOverflow, sNegative, sZero, sPar, sCarry;
    logic [2:0] sSelDecoA, sSelDecoB, sSelDecoC, sSelAlu;
    logic       sBusy, sDone, sDivZero;

    logic [7:0] k0, k1;
    logic [7:0] regs [0:2];
    logic [7:0] bus_a, bus_b, alu_res;
    logic [8:0] wide;

    int cycle_cnt = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int q;
        int r;
        int dz;
        int lat;
        int start;
    } exp_t;
    exp_t sb[$];

    div_statemachine #(
        .SELECTIONALU(3), .SELECTIONDECO(3), .SRC_N(6), .SRC_D(7)
    ) dut (
        .clk(clk), .lowRst(lowRst), .sStart(sStart),
        .sOverflow(sOverflow), .sNegative(sNegative), .sZero(sZero),
        .sPar(sPar), .sCarry(sCarry),
        .sSelDecoA(sSelDecoA), .sSelDecoB(sSelDecoB), .sSelDecoC(sSelDecoC),
        .sSelAlu(sSelAlu), .sBusy(sBusy), .sDone(sDone), .sDivZero(sDivZero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    function automatic logic [7:0] readBus(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return regs[idx];
            3'd6:             return k0;
            3'd7:             return k1;
            default:          return 8'd0;
        endcase
    endfunction

    // Datapath model: ALU with borrow-as-carry on SUB, registers written on the clock edge.
    always_comb begin
        bus_a = readBus(sSelDecoA);
        bus_b = readBus(sSelDecoB);
        case (sSelAlu)
            3'd0:    wide = {1'b0, bus_a} + {1'b0, bus_b};
            3'd1:    wide = {1'b0, bus_a} - {1'b0, bus_b};
            3'd2:    wide = {1'b0, bus_a} + 9'd1;
            3'd3:    wide = {1'b0, bus_a};
            3'd4:    wide = {1'b0, bus_a & bus_b};
            3'd5:    wide = {1'b0, bus_a | bus_b};
            3'd6:    wide = {1'b0, bus_a ^ bus_b};
            default: wide = {bus_a, 1'b0};
        endcase
        alu_res   = wide[7:0];
        sCarry    = wide[8];
        sZero     = (alu_res == 8'd0);
        sNegative = alu_res[7];
        sPar      = ^alu_res;
        sOverflow = 1'b0;
    end

    always @(posedge clk or negedge lowRst) begin
        if (!lowRst) begin
            regs[0] <= 8'd0;
            regs[1] <= 8'd0;
            regs[2] <= 8'd0;
        end else if (sSelDecoC <= 3'd2) begin
            regs[sSelDecoC] <= alu_res;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkIdleWord(input string tag);
        checkOutput({tag, "_busy"}, int'(sBusy), 0);
        checkOutput({tag, "_done"}, int'(sDone), 0);
        checkOutput({tag, "_divzero"}, int'(sDivZero), 0);
        checkOutput({tag, "_selA"}, int'(sSelDecoA), 3);
        checkOutput({tag, "_selB"}, int'(sSelDecoB), 3);
        checkOutput({tag, "_selC"}, int'(sSelDecoC), 7);
        checkOutput({tag, "_alu"}, int'(sSelAlu), 0);
    endtask

    function automatic exp_t refModel(input int n, input int d, input int start);
        exp_t e;
        e.start = start;
        if (d == 0) begin
            e.q = 0; e.r = n; e.dz = 1; e.lat = 5;
        end else begin
            e.q = n / d; e.r = n % d; e.dz = 0; e.lat = 6 + 3 * (n / d);
        end
        return e;
    endfunction

    task automatic waitIdle();
        int guard = 0;
        while (sBusy && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: got busy, expected idle");
        end
    endtask

    task automatic applyStimulus(input int n, input int d, input bit hold, output int start);
        @(negedge clk);
        waitIdle();
        k0 = 8'(n);
        k1 = 8'(d);
        sStart = 1'b1;
        @(posedge clk);
        #1;
        start = cycle_cnt;
        sb.push_back(refModel(n, d, start));
        @(negedge clk);
        if (!hold) sStart = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
    endtask

    // Monitor: scores every completion pulse against the oldest outstanding request.
    always @(negedge clk) begin
        if (lowRst) begin
            if (sDivZero && !sDone) begin
                checkOutput("divzero_without_done", 1, 0);
            end
            if (sDone) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("quotient", int'(regs[2]), e.q);
                    checkOutput("remainder", int'(regs[0]), e.r);
                    checkOutput("divzero", int'(sDivZero), e.dz);
                    checkOutput("latency", cycle_cnt - e.start + 1, e.lat);
                end
            end
        end
    end

    initial begin
        int st;
        int st2;
        int n;
        int d;
        int guard;

        lowRst = 1'b0;
        sStart = 1'b0;
        k0 = 8'd4;
        k1 = 8'd5;
        @(negedge clk);
        checkIdleWord("reset");
        @(negedge clk);
        lowRst = 1'b1;
        @(negedge clk);
        checkIdleWord("idle");

        $display("[TB] directed divisions");
        applyStimulus(20, 5, 1'b0, st);
        applyStimulus(4, 5, 1'b0, st);
        applyStimulus(255, 1, 1'b0, st);
        applyStimulus(0, 7, 1'b0, st);
        applyStimulus(9, 0, 1'b0, st);
        guard = 0;
        while (!sDone && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("err_pulse_seen", int'(sDone), 1);
        @(negedge clk);
        checkOutput("after_err_busy", int'(sBusy), 0);
        checkOutput("after_err_done", int'(sDone), 0);
        drain();

        $display("[TB] reset during SUBT");
        applyStimulus(20, 5, 1'b0, st);
        while (cycle_cnt < st + 5) @(negedge clk);
        #1 lowRst = 1'b0;
        #1 checkIdleWord("midloop_reset");
        sb.delete();
        @(negedge clk);
        lowRst = 1'b1;
        applyStimulus(20, 5, 1'b0, st);
        drain();

        $display("[TB] start toggled while busy, then held across DONE");
        applyStimulus(20, 5, 1'b1, st);
        sStart = 1'b0;
        @(negedge clk);
        sStart = 1'b1;
        @(negedge clk);
        sStart = 1'b0;
        @(negedge clk);
        sStart = 1'b1;
        st2 = st + (6 + 3 * 4) + 1;
        sb.push_back(refModel(20, 5, st2));
        while (cycle_cnt < st2 + 2) @(negedge clk);
        sStart = 1'b0;
        drain();

        $display("[TB] randomized divisions");
        for (int i = 0; i < 24; i++) begin
            n = int'($urandom_range(0, 255));
            case ($urandom_range(0, 5))
                0:       d = 0;
                1:       d = int'($urandom_range(1, 4));
                default: d = int'($urandom_range(1, 255));
            endcase
            applyStimulus(n, d, 1'b0, st);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
